// File: rtl/des_round_core_if.sv
// Bus between the DES round controller and des_round_core.
//
// Signals:
//   key      - 56-bit DES key with parity dropped; bit 55 is the key MSB
//   roundSel - round index 0..15
//   decrypt  - 0: encrypt subkey order, 1: decrypt subkey order
//   R        - right half fed to the f-function; bit 1 is the MSB
//   K_sub    - selected round subkey; bit 1 is the MSB
//   P        - f(R, K_sub); bit 1 is the MSB
//   tick     - one-cycle round-step enable from the divider
//
// Modports:
//   master - the side that supplies key/round/R and consumes results
//   slave  - des_round_core
interface des_round_core_if;
  logic [55:0] key;
  logic [3:0]  roundSel;
  logic        decrypt;
  logic [1:32] R;
  logic [1:48] K_sub;
  logic [1:32] P;
  logic        tick;

  modport master (
    output key, roundSel, decrypt, R,
    input  K_sub, P, tick
  );

  modport slave (
    input  key, roundSel, decrypt, R,
    output K_sub, P, tick
  );
endinterface

// File: rtl/des_round_core.sv
// DES round datapath plus round-step clock-enable divider.
//
// Subkey path: parity-stripped key -> PC-1 -> C/D rotated by the cumulative
// shift count of the selected round -> PC-2 -> K_sub.
// f-function:  E(R) xor K_sub -> S1..S8 -> P table -> P.
// Divider:     free-running DIV_LOG2-bit counter; tick is high while the
//              counter is all-ones (one pulse every 2^DIV_LOG2 cycles).
//
// Ports:
//   clk - system clock
//   rst - synchronous, active-high reset (divider, and output registers
//         when present)
//   bus - des_round_core_if.slave (key, roundSel, decrypt, R in;
//         K_sub, P, tick out)
//
// Parameters:
//   DIV_LOG2 - tick period is 2^DIV_LOG2 clk cycles, legal range 1..24
//
// Build option:
//   DES_ROUND_OUT_REG_EN - when defined, K_sub and P are registered
//   (1-cycle latency, reset to 0, updated every cycle regardless of tick).
//   When undefined, K_sub and P are purely combinational.
module des_round_core #(
  parameter int DIV_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  des_round_core_if.slave bus
);

  // All tables use DES numbering: entries are 1-based, bit 1 is the MSB.
  localparam int PC1_TBL [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int E_TBL [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Total left rotation of C/D before PC-2 for subkey K(n+1).
  // Round 16 totals 28, i.e. back to C0/D0.
  localparam int CUM_SHIFT [0:15] = '{
    1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28
  };

  // S1..S8 flattened: index = box*64 + row*16 + column.
  localparam logic [3:0] SBOX_TBL [0:511] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  // Re-insert the dropped parity positions (every 8th bit) as 0 so the
  // standard 64-bit PC-1 table applies unchanged.
  function automatic logic [1:64] expand_key(input logic [55:0] k);
    logic [1:64] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      for (int b = 1; b <= 7; b++) begin
        r[8*j+b] = k[56-(7*j+b)];
      end
    end
    return r;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 1; i <= 56; i++) r[i] = k[PC1_TBL[i-1]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    for (int i = 1; i <= 48; i++) r[i] = cd[PC2_TBL[i-1]];
    return r;
  endfunction

  // Left rotate toward bit 1; n = 28 degenerates cleanly to identity.
  function automatic logic [1:28] rotl28(input logic [1:28] v, input int n);
    return (v << n) | (v >> (28 - n));
  endfunction

  function automatic logic [1:48] e_expand(input logic [1:32] r);
    logic [1:48] o;
    for (int i = 1; i <= 48; i++) o[i] = r[E_TBL[i-1]];
    return o;
  endfunction

  // Row from the outer bits of each 6-bit group, column from the inner four.
  function automatic logic [1:32] sbox_sub(input logic [1:48] x);
    logic [1:32] o;
    logic [5:0]  six;
    int          idx;
    o = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[6*s+1 +: 6];
      idx = s*64 + 16*int'({six[5], six[0]}) + int'(six[4:1]);
      o[4*s+1 +: 4] = SBOX_TBL[idx];
    end
    return o;
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] s);
    logic [1:32] o;
    for (int i = 1; i <= 32; i++) o[i] = s[P_TBL[i-1]];
    return o;
  endfunction

  logic [3:0]          round_idx;
  logic [1:56]         cd0;
  logic [1:56]         cd_rot;
  logic [1:48]         k_sub_p0;
  logic [1:32]         f_out_p0;
  logic [DIV_LOG2-1:0] cnt;

  // Stage p0: combinational subkey select and f-function.
  // Decrypt walks the schedule backwards: roundSel r picks K(16-r).
  always_comb begin
    round_idx = bus.decrypt ? (4'd15 - bus.roundSel) : bus.roundSel;
    cd0       = pc1(expand_key(bus.key));
    cd_rot    = {rotl28(cd0[1:28],  CUM_SHIFT[round_idx]),
                 rotl28(cd0[29:56], CUM_SHIFT[round_idx])};
    k_sub_p0  = pc2(cd_rot);
    f_out_p0  = p_perm(sbox_sub(e_expand(bus.R) ^ k_sub_p0));
  end

`ifdef DES_ROUND_OUT_REG_EN
  logic [1:48] k_sub_p1;
  logic [1:32] f_out_p1;

  // Stage p1: output registers, loaded every cycle independent of tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_sub_p1 <= '0;
      f_out_p1 <= '0;
    end else begin
      k_sub_p1 <= k_sub_p0;
      f_out_p1 <= f_out_p0;
    end
  end

  assign bus.K_sub = k_sub_p1;
  assign bus.P     = f_out_p1;
`else
  assign bus.K_sub = k_sub_p0;
  assign bus.P     = f_out_p0;
`endif

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + DIV_LOG2'(1);
  end

  assign bus.tick = &cnt;

endmodule

// File: tb/tb_des_round_core.sv
module tb_des_round_core;
  localparam int DIV_LOG2 = 2;
  localparam int PERIOD   = 1 << DIV_LOG2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_round_core_if bus();

  des_round_core #(.DIV_LOG2(DIV_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference tables, written in the textbook form (1-based DES positions).
  int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int ET  [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int PT  [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  // Subkey K(round_no), round_no 1..16, by stepping the schedule round by
  // round with single-bit rotations.
  function automatic logic [47:0] ref_subkey(input logic [55:0] key, input int round_no);
    logic [63:0] k64;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks;
    k64 = '0;
    for (int q = 1; q <= 56; q++) k64[64 - (q + (q - 1) / 7)] = key[56 - q];
    for (int i = 1; i <= 56; i++) cd[56 - i] = k64[64 - PC1[i-1]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 1; r <= round_no; r++) begin
      for (int s = 0; s < SHIFTS[r-1]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    cd = {c, d};
    for (int i = 1; i <= 48; i++) ks[48 - i] = cd[56 - PC2[i-1]];
    return ks;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] so, po;
    logic [5:0]  six;
    for (int i = 1; i <= 48; i++) x[48 - i] = r[32 - ET[i-1]];
    x = x ^ k;
    for (int s = 0; s < 8; s++) begin
      six = x[47 - 6*s -: 6];
      so[31 - 4*s -: 4] = 4'(SB[s][{six[5], six[0]}][six[4:1]]);
    end
    for (int i = 1; i <= 32; i++) po[32 - i] = so[32 - PT[i-1]];
    return po;
  endfunction

  function automatic logic [47:0] ref_select(input logic [55:0] key, input logic [3:0] rs, input logic dec);
    return ref_subkey(key, dec ? 16 - int'(rs) : int'(rs) + 1);
  endfunction

  logic [47:0] prev_k;
  logic [31:0] prev_p;

  // Drive on a falling edge; check right away (combinational build sees the
  // new value, registered build still holds the previous one), then again
  // after the next rising edge.
  task automatic apply(input string tag, input logic [55:0] key, input logic [3:0] rs,
                       input logic dec, input logic [31:0] r,
                       input logic [47:0] exp_k, input logic [31:0] exp_p);
    bus.key = key; bus.roundSel = rs; bus.decrypt = dec; bus.R = r;
    #1;
`ifdef DES_ROUND_OUT_REG_EN
    check({tag, "_k_hold"}, 64'(bus.K_sub), 64'(prev_k));
    check({tag, "_p_hold"}, 64'(bus.P), 64'(prev_p));
`else
    check({tag, "_k_now"}, 64'(bus.K_sub), 64'(exp_k));
    check({tag, "_p_now"}, 64'(bus.P), 64'(exp_p));
`endif
    @(negedge clk);
    check({tag, "_k"}, 64'(bus.K_sub), 64'(exp_k));
    check({tag, "_p"}, 64'(bus.P), 64'(exp_p));
    prev_k = exp_k;
    prev_p = exp_p;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [55:0] TKEY = 56'h12695BC9B7B7F8;

  initial begin
    logic [55:0] k;
    logic [3:0]  rs;
    logic        dec;
    logic [31:0] r;
    logic [47:0] ek;

    rst = 1'b1;
    bus.key = '0; bus.roundSel = 4'd0; bus.decrypt = 1'b0; bus.R = '0;

    repeat (3) begin
      @(negedge clk);
      check("tick_in_rst", 64'(bus.tick), 64'd0);
`ifdef DES_ROUND_OUT_REG_EN
      check("p_in_rst", 64'(bus.P), 64'd0);
      check("k_in_rst", 64'(bus.K_sub), 64'd0);
`else
      check("p_zero_comb", 64'(bus.P), 64'hD8D8DBBC);
`endif
    end

    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", n), 64'(bus.tick), 64'((n % PERIOD) == PERIOD - 1));
      if (n == 1) begin
        check("p_zero_after_rel", 64'(bus.P), 64'hD8D8DBBC);
        check("k_zero_after_rel", 64'(bus.K_sub), 64'd0);
      end
    end

    // Reset in the middle of a count.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("tick_mid_rst", 64'(bus.tick), 64'd0);
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("tick_r%0d", n), 64'(bus.tick), 64'((n % PERIOD) == PERIOD - 1));
    end

    prev_k = 48'd0;
    prev_p = 32'hD8D8DBBC;

    apply("enc_r0",  TKEY, 4'd0,  1'b0, 32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h234AA9BB);
    apply("enc_r15", TKEY, 4'd15, 1'b0, 32'hF0AAF0AA, 48'hCB3D8B0E17F5,
          ref_f(32'hF0AAF0AA, 48'hCB3D8B0E17F5));
    apply("dec_r0",  TKEY, 4'd0,  1'b1, 32'h0, 48'hCB3D8B0E17F5, ref_f(32'h0, 48'hCB3D8B0E17F5));
    apply("dec_r15", TKEY, 4'd15, 1'b1, 32'h0, 48'h1B02EFFC7072, ref_f(32'h0, 48'h1B02EFFC7072));
    apply("zero_r7", 56'd0, 4'd7, 1'b1, 32'h0, 48'd0, 32'hD8D8DBBC);
    apply("r_change", 56'd0, 4'd7, 1'b1, 32'h12345678, 48'd0, ref_f(32'h12345678, 48'd0));

    for (int i = 0; i < 150; i++) begin
      k   = {24'($urandom), $urandom};
      rs  = 4'($urandom_range(0, 15));
      dec = 1'($urandom);
      r   = $urandom;
      ek  = ref_select(k, rs, dec);
      apply($sformatf("rnd%0d", i), k, rs, dec, r, ek, ref_f(r, ek));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/des_round_core.md
Name: des_round_core

Overview:
- Combinational DES round datapath: key-schedule subkey selection (PC-1/rotate/PC-2 per round) and f-function (E-expansion, subkey XOR, S-boxes, P-permutation).
- Also contains a synchronous clock-enable divider that produces a slow round-step tick.
- Sits inside the DES top level, between the L/R round registers and the round counter.
- Replaces the separate subkey-select, f-function and clock-divide blocks with one clocked unit.

Parameters:
- DIV_LOG2, default 2: tick period is 2^DIV_LOG2 clk cycles; legal range 1..24.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key  input  56  DES key with parity dropped: {k64[63:57], k64[55:49], …, k64[7:1]}; bit 55 is the key MSB.
- roundSel  input  4  round index 0..15.
- decrypt  input  1  0 selects encrypt subkey order, 1 selects decrypt order.
- R  input  [1:32]  right half fed to the f-function; bit 1 is MSB.
- K_sub  output  [1:48]  selected round subkey.
- P  output  [1:32]  f(R, K_sub).
- tick  output  1  one-cycle enable pulse from the divider.

Behaviour:
- Single clock domain.
- rst is synchronous and active-high; it acts only at a posedge clk.

Subkey path (combinational, zero latency):
- Map key to the 64-bit key with parity positions set to 0.
- Apply PC-1 to get C0/D0 (28 bits each).
- Rotate C and D left by the cumulative DES shift count for round n. Per-round shifts are 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Apply PC-2 to get K_sub.
- Encrypt: roundSel = r yields DES subkey K(r+1).
- Decrypt: roundSel = r yields K(16−r).
- All 16 values of roundSel are legal; there is no wrap condition.

f-function (combinational, zero latency):
- Compute E(R), 48 bits, using the standard DES E table.
- XOR with K_sub.
- Feed eight 6-bit groups to S1..S8. Row = outer bits, column = inner 4 bits.
- Concatenate the S-box outputs S1 first, then apply the DES P table to get P.
- Bit 1 is MSB throughout.

Divider:
- Free-running DIV_LOG2-bit up-counter cnt.
- tick = 1 exactly when cnt == all-ones, giving one pulse per 2^DIV_LOG2 cycles.
- On rst: cnt ← 0, so tick = 0. The first tick comes 2^DIV_LOG2 − 1 cycles after rst deasserts.
- rst asserted mid-count restarts the sequence from 0.
- No derived clocks; downstream logic uses tick as an enable on clk.

Reset and X handling:
- K_sub and P have no reset state in the default build; they follow inputs immediately.
- X on key, R, roundSel or decrypt propagates only to K_sub and P, never to tick.

Optional Feature:
- Macro: DES_ROUND_OUT_REG_EN.
- Defined:
  - K_sub and P are registered on posedge clk, giving 1-cycle latency from inputs.
  - Both registers reset to 0 on rst.
  - They update every cycle, independent of tick.
- Undefined: K_sub and P are purely combinational, as described in Behaviour.
- tick timing is identical in both builds.

Test Plan:
- Subkey, encrypt: key=56'h12695BC9B7B7F8 (k64 133457799BBCDFF1), decrypt=0.
  - roundSel=0 → K_sub=48'h1B02EFFC7072.
  - roundSel=15 → K_sub=48'hCB3D8B0E17F5.
- Subkey, decrypt: same key, decrypt=1.
  - roundSel=0 → 48'hCB3D8B0E17F5.
  - roundSel=15 → 48'h1B02EFFC7072.
- f-function, zero inputs: key=0, R=32'h00000000, any roundSel → K_sub=0, P=32'hD8D8DBBC.
- f-function, DES round 1: key=56'h12695BC9B7B7F8, roundSel=0, decrypt=0, R=32'hF0AAF0AA → P=32'h234AA9BB.
- Divider, DIV_LOG2=2:
  - rst high 3 cycles, then low → tick=0 during reset.
  - tick high on the 3rd cycle after release, then every 4th cycle.
  - Assert rst for 1 cycle mid-count → tick returns to 0 and the count restarts.
- DES_ROUND_OUT_REG_EN defined:
  - Repeat the zero-input case → P=0 during rst.
  - P=32'hD8D8DBBC one clk after inputs are applied.
  - A change of R shows on P one cycle later.
